// File: rtl/eth_tx_arb.sv
// +-----------------------------------------------------------------------+
// | Module : eth_tx_arb                                                   |
// | Two-requester round-robin arbiter loading whole frames into the TX    |
// | payload FIFO, then handing off to TX control and holding the IFG.     |
// | Rev    : 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module eth_tx_arb #(
  parameter int pMax_Bytes  = 1500,
  parameter int pIFG_Cycles = 48
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Req0_Valid,
  input  logic [7:0] Req0_Data,
  input  logic       Req0_Last,
  output logic       Req0_Ready,
  input  logic       Req1_Valid,
  input  logic [7:0] Req1_Data,
  input  logic       Req1_Last,
  output logic       Req1_Ready,
  output logic       Fifo_Wr,
  output logic [7:0] Fifo_Din,
  input  logic       Fifo_Full,
  output logic       Eth_Pkt_Rdy,
  input  logic       Tx_En,
  output logic [1:0] Grant,
  output logic       Busy,
  output logic       Trunc_Err
);

  localparam int                 c_IFG_W     = (pIFG_Cycles > 1) ? $clog2(pIFG_Cycles) : 1;
  localparam logic [c_IFG_W-1:0] c_IFG_LAST  = c_IFG_W'(pIFG_Cycles - 1);
  localparam logic [10:0]        c_BYTE_LAST = 11'(pMax_Bytes - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_START   = 3'd2,
    S_WAIT_TX = 3'd3,
    S_IFG     = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_grant, w_grant_nxt;
  logic                 r_last_served, w_last_served_nxt;
  logic [10:0]          r_byte_cnt, w_byte_cnt_nxt;
  logic [c_IFG_W-1:0]   r_ifg_cnt, w_ifg_cnt_nxt;
  logic                 r_tx_seen, w_tx_seen_nxt;

  logic w_xfer;
  logic w_sel_last;
  logic w_pick1;

  assign Req0_Ready  = (r_state == S_LOAD) && r_grant[0] && !Fifo_Full;
  assign Req1_Ready  = (r_state == S_LOAD) && r_grant[1] && !Fifo_Full;
  assign w_xfer      = (Req0_Valid && Req0_Ready) || (Req1_Valid && Req1_Ready);
  assign w_sel_last  = r_grant[1] ? Req1_Last : Req0_Last;
  assign Fifo_Wr     = w_xfer;
  assign Fifo_Din    = r_grant[1] ? Req1_Data : Req0_Data;
  assign Trunc_Err   = w_xfer && !w_sel_last && (r_byte_cnt == c_BYTE_LAST);
  assign Eth_Pkt_Rdy = (r_state == S_START);
  assign Busy        = (r_state != S_IDLE);
  assign Grant       = r_grant;

  // On contention the requester that did not finish the previous frame wins.
  assign w_pick1 = Req1_Valid && (!Req0_Valid || !r_last_served);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state       <= S_IDLE;
      r_grant       <= 2'b00;
      r_last_served <= 1'b1;
      r_byte_cnt    <= '0;
      r_ifg_cnt     <= '0;
      r_tx_seen     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_last_served <= w_last_served_nxt;
      r_byte_cnt    <= w_byte_cnt_nxt;
      r_ifg_cnt     <= w_ifg_cnt_nxt;
      r_tx_seen     <= w_tx_seen_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_last_served_nxt = r_last_served;
    w_byte_cnt_nxt    = r_byte_cnt;
    w_ifg_cnt_nxt     = r_ifg_cnt;
    w_tx_seen_nxt     = r_tx_seen;
    case (r_state)
      S_IDLE: begin
        if (Req0_Valid || Req1_Valid) begin
          w_grant_nxt    = w_pick1 ? 2'b10 : 2'b01;
          w_byte_cnt_nxt = '0;
          w_state_nxt    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_xfer) begin
          w_byte_cnt_nxt = r_byte_cnt + 11'd1;
          // A truncated frame still counts as served for fairness.
          if (w_sel_last || Trunc_Err) begin
            w_last_served_nxt = r_grant[1];
            w_state_nxt       = S_START;
          end
        end
      end
      S_START: begin
        w_tx_seen_nxt = 1'b0;
        w_state_nxt   = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (Tx_En) begin
          w_tx_seen_nxt = 1'b1;
        end else if (r_tx_seen) begin
          w_grant_nxt   = 2'b00;
          w_ifg_cnt_nxt = '0;
          w_state_nxt   = S_IFG;
        end
      end
      S_IFG: begin
        if (r_ifg_cnt == c_IFG_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_ifg_cnt_nxt = r_ifg_cnt + c_IFG_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire
